stereo_col_interp: RTL
======================

STEREO_COL_INTERP -- requirements
Module: stereo_col_interp

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter N_PAIRS, default 2, meaning L/R pixel pairs per input beat; DATA_W = 2*N_PAIRS*PIX_W (default 32).
REQ-003 SHALL have port aclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port areset, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port mode, input, 1, meaning 0 = average, 1 = nearest; sampled per output computation.
REQ-006 SHALL have ports s_axis_lr_tdata/tvalid/tready/tlast/tuser, in/in/out/in/in, DATA_W/1/1/1/1, meaning the interleaved stereo input stream; tlast = end of line, tuser = start of frame.
REQ-007 SHALL have ports m_axis_l_tdata/tvalid/tready/tlast/tuser, out/out/in/out/out, DATA_W/1/1/1/1, meaning the full-resolution left stream.
REQ-008 SHALL have ports m_axis_r_* with the same widths and directions as m_axis_l_*, meaning the full-resolution right stream.

Function
REQ-009 Input lane k (bits k*PIX_W +: PIX_W) of line beat b SHALL be column c = b*2*N_PAIRS + k; even c = left sample, odd c = right sample.
REQ-010 Output beat b lane k SHALL be column c of the respective image; real columns pass through unchanged.
REQ-011 In average mode a missing column SHALL be (X[c-1] + X[c+1] + 1) >> 1, computed at PIX_W+1 bits with no truncated bits.
REQ-012 In nearest mode a missing column SHALL be X[c-1].
REQ-013 At line edges: right column 0 SHALL use R[1]; left last column SHALL use L[last-1]; history SHALL NOT cross tlast.
REQ-014 The block SHALL hold one pending input beat and emit beat b only after beat b+1 is accepted, or after beat b carried tlast.
REQ-015 FSM states: EMPTY (no pending), PEND (one beat pending), FLUSH (pending beat is the line's tlast beat, awaiting output slot).
REQ-016 Transitions: EMPTY + accept (!tlast) -> PEND; EMPTY + accept (tlast) -> FLUSH; PEND + accept (!tlast) -> PEND with output load; PEND + accept (tlast) -> FLUSH with output load; FLUSH + output slot free -> EMPTY with output load.
REQ-017 s_axis_lr_tready SHALL be 1 when state != FLUSH and (state == EMPTY or the output slot is empty or drains this cycle).
REQ-018 Output slot: the L and R beats SHALL load together; each m_*_tvalid SHALL drop independently after its own handshake; the slot is free when both are done.
REQ-019 m_*_tvalid and m_*_tdata SHALL be stable while tvalid=1 and tready=0.
REQ-020 m_*_tlast SHALL be 1 on the beat derived from the tlast input beat; m_*_tuser SHALL be 1 on the beat derived from the tuser input beat.
REQ-021 Latency: output SHALL be valid the cycle after the loading transition in REQ-016.
REQ-022 A one-beat line SHALL apply both edge rules within that beat.

Reset
REQ-023 With areset=1 at a clock edge: state = EMPTY; pending, history and output slot invalidated; all m_*_tvalid = 0; s_axis_lr_tready = 0 during reset.
REQ-024 Reset mid-line SHALL discard pending and history data; the first accepted beat after reset SHALL be treated as the start of a line.

Structure
REQ-025 Package stereo_pkg SHALL hold the default PIX_W and N_PAIRS, the mode encoding, and the FSM state enum.
REQ-026 Sub-module col_interp_pix SHALL compute one missing pixel from (prev, next, mode); it SHALL be instantiated 2*N_PAIRS times.

Verification (PIX_W=8, N_PAIRS=2; lanes listed 0..3)
REQ-027 Average mode: beats [10,20,30,40] then [50,60,70,80] with tlast -> L [10,20,30,40],[50,60,70,70]; R [20,20,30,40],[50,60,70,80]; tlast set on the second beat.
REQ-028 Nearest mode, same input -> L [10,10,30,30],[50,50,70,70]; R [20,20,20,40],[40,60,60,80].
REQ-029 Rounding: beats [255,0,254,0],[0,0,0,0] with tlast, average mode -> L lane1 = 255 (no wrap or truncation).
REQ-030 Backpressure: m_axis_l_tready=1, m_axis_r_tready held 0 for 5 cycles -> L handshakes once; R data stays stable; s_axis_lr_tready=0 until R accepts; no beat lost.
REQ-031 Single-beat line [1,2,3,4] with tlast and tuser -> L [1,2,3,3], R [2,2,3,4], tlast=1, tuser=1.
REQ-032 areset asserted while PEND -> all tvalid 0 the next cycle; a subsequent two-beat line reproduces the REQ-027 output exactly.

Source files
------------

// File: rtl/stereo_pkg.sv
// stereo_pkg: shared defaults, mode encoding and FSM states for stereo column interpolation
package stereo_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int N_PAIRS_DEF = 2;
  typedef enum logic {MODE_AVG, MODE_NEAREST} mode_t;
  typedef enum logic [1:0] {EMPTY, PEND, FLUSH} state_t;
endpackage

// File: rtl/col_interp_pix.sv
// col_interp_pix: one missing pixel from its neighbours, rounded average or nearest-previous
module col_interp_pix
  import stereo_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] prev,
  input  logic [PIX_W-1:0] nxt,
  input  logic             mode,
  output logic [PIX_W-1:0] pix
);
  always_comb pix = mode == MODE_NEAREST ? prev : PIX_W'(({1'b0, prev} + {1'b0, nxt} + (PIX_W+1)'(1)) >> 1);
endmodule

// File: rtl/stereo_col_interp.sv
// stereo_col_interp: splits an interleaved L/R stream into full-resolution left and right streams
module stereo_col_interp
  import stereo_pkg::*;
#(
  parameter  int PIX_W   = PIX_W_DEF,
  parameter  int N_PAIRS = N_PAIRS_DEF,
  localparam int LANES   = 2*N_PAIRS,
  localparam int DATA_W  = LANES*PIX_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              mode,
  input  logic [DATA_W-1:0] s_axis_lr_tdata,
  input  logic              s_axis_lr_tvalid,
  output logic              s_axis_lr_tready,
  input  logic              s_axis_lr_tlast,
  input  logic              s_axis_lr_tuser,
  output logic [DATA_W-1:0] m_axis_l_tdata,
  output logic              m_axis_l_tvalid,
  input  logic              m_axis_l_tready,
  output logic              m_axis_l_tlast,
  output logic              m_axis_l_tuser,
  output logic [DATA_W-1:0] m_axis_r_tdata,
  output logic              m_axis_r_tvalid,
  input  logic              m_axis_r_tready,
  output logic              m_axis_r_tlast,
  output logic              m_axis_r_tuser
);
  state_t state, state_nxt;
  logic [DATA_W-1:0] pend, l_nxt, r_nxt;
  logic [PIX_W-1:0] hist;
  logic pend_last, pend_user, pend_first, o_last, o_user, l_vld, r_vld, slot_ok, accept, load;
  always_comb slot_ok = (!l_vld || m_axis_l_tready) && (!r_vld || m_axis_r_tready);
  always_comb begin
    s_axis_lr_tready = !areset && state != FLUSH && (state == EMPTY || slot_ok);
    accept = s_axis_lr_tvalid && s_axis_lr_tready;
    load = (state == PEND && accept) || (state == FLUSH && slot_ok);
  end
  always_comb state_nxt = accept ? (s_axis_lr_tlast ? FLUSH : PEND) : (state == FLUSH && slot_ok ? EMPTY : state);
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= EMPTY;
      l_vld <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      l_vld <= load || (l_vld && !m_axis_l_tready);
      r_vld <= load || (r_vld && !m_axis_r_tready);
    end
  end
  always_ff @(posedge aclk) begin
    if (accept) begin
      pend <= s_axis_lr_tdata;
      pend_last <= s_axis_lr_tlast;
      pend_user <= s_axis_lr_tuser;
      pend_first <= state == EMPTY;
      hist <= pend[DATA_W-1 -: PIX_W];
    end
    if (load) begin
      m_axis_l_tdata <= l_nxt;
      m_axis_r_tdata <= r_nxt;
      o_last <= pend_last;
      o_user <= pend_user;
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PIX_W-1:0] prev, nxt, ip;
    if (k % 2 == 1 && k == LANES-1) begin : g_l_edge
      assign prev = pend[(k-1)*PIX_W +: PIX_W];
      assign nxt = pend_last ? pend[(k-1)*PIX_W +: PIX_W] : s_axis_lr_tdata[PIX_W-1:0];
    end else if (k % 2 == 1) begin : g_l_mid
      assign prev = pend[(k-1)*PIX_W +: PIX_W];
      assign nxt = pend[(k+1)*PIX_W +: PIX_W];
    end else if (k == 0) begin : g_r_edge
      assign prev = pend_first ? pend[PIX_W +: PIX_W] : hist;
      assign nxt = pend[PIX_W +: PIX_W];
    end else begin : g_r_mid
      assign prev = pend[(k-1)*PIX_W +: PIX_W];
      assign nxt = pend[(k+1)*PIX_W +: PIX_W];
    end
    col_interp_pix #(.PIX_W(PIX_W)) u_pix (.prev(prev), .nxt(nxt), .mode(mode), .pix(ip));
    assign l_nxt[k*PIX_W +: PIX_W] = k % 2 == 1 ? ip : pend[k*PIX_W +: PIX_W];
    assign r_nxt[k*PIX_W +: PIX_W] = k % 2 == 1 ? pend[k*PIX_W +: PIX_W] : ip;
  end
  assign m_axis_l_tvalid = l_vld;
  assign m_axis_r_tvalid = r_vld;
  assign m_axis_l_tlast = o_last;
  assign m_axis_r_tlast = o_last;
  assign m_axis_l_tuser = o_user;
  assign m_axis_r_tuser = o_user;
endmodule
